cmult_arbiter: RTL

CMULT_ARBITER -- requirements
Module: cmult_arbiter

---
 rtl/fft_pkg.sv | 38 +++
 rtl/multip.sv | 34 +++
 rtl/cmult_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default component widths and lane packing/arbitration helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fft_pkg;

   localparam int NBITS_DEF      = 10;
   localparam int NBITSCOEFF_DEF = 11;
   localparam int NREQ_MAX       = 8;

   // Result of a round-robin search: found flag plus winning lane index.
   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } rr_pick_t;

   // LSB position of lane 'lane' in a bus packed as NREQ slices of {real, imag}.
   function automatic int lane_lsb(input int lane, input int comp_width);
      return lane * 2 * comp_width;
   endfunction

   // First valid lane at or above ptr, wrapping modulo nreq (nreq a power of two).
   function automatic rr_pick_t rr_pick(input logic [NREQ_MAX-1:0] vld,
                                        input logic [2:0]          ptr,
                                        input int                  nreq);
      rr_pick_t   r;
      logic [2:0] idx;
      r = '0;
      for (int k = 0; k < NREQ_MAX; k++) begin
         idx = 3'((int'(ptr) + k) & (nreq - 1));
         if ((k < nreq) && !r.found && vld[idx]) begin
            r.found = 1'b1;
            r.idx   = idx;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/multip.sv
// Combinational complex multiplier: (mr + j*mi) * (cr + j*ci), full precision, no rounding.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module multip import fft_pkg::*; #(
   parameter int NBITS      = NBITS_DEF,
   parameter int NBITScoeff = NBITSCOEFF_DEF,
   parameter int NBITS_out  = NBITS + NBITScoeff + 1
) (
   input  logic [2*NBITS-1:0]      muestra,
   input  logic [2*NBITScoeff-1:0] coeff,
   output logic [2*NBITS_out-1:0]  result
);

   logic signed [NBITS-1:0]      mr, mi;
   logic signed [NBITScoeff-1:0] cr, ci;
   logic signed [NBITS_out-1:0]  p_rr, p_ii, p_ri, p_ir;
   logic signed [NBITS_out-1:0]  re, im;

   // Operands are sign-extended to the result width first so every product and sum is exact.
   always_comb begin
      mr     = muestra[2*NBITS-1:NBITS];
      mi     = muestra[NBITS-1:0];
      cr     = coeff[2*NBITScoeff-1:NBITScoeff];
      ci     = coeff[NBITScoeff-1:0];
      p_rr   = NBITS_out'(mr) * NBITS_out'(cr);
      p_ii   = NBITS_out'(mi) * NBITS_out'(ci);
      p_ri   = NBITS_out'(mr) * NBITS_out'(ci);
      p_ir   = NBITS_out'(mi) * NBITS_out'(cr);
      re     = p_rr - p_ii;
      im     = p_ri + p_ir;
      result = {re, im};
   end

endmodule

// File: rtl/cmult_arbiter.sv
// Round-robin arbiter sharing one complex multiplier among NREQ butterfly lanes.
// Latency: 2 cycles from operand transfer to out_valid; one result per cycle sustained.
// Backpressure: out_ready low freezes stage 2, then stage 1; req_ready drops once stage 1 is full.
module cmult_arbiter import fft_pkg::*; #(
   parameter int NBITS      = NBITS_DEF,
   parameter int NBITScoeff = NBITSCOEFF_DEF,
   parameter int NREQ       = 4,
   parameter int NBITS_out  = NBITS + NBITScoeff + 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NREQ-1:0]                req_valid,
   output logic [NREQ-1:0]                req_ready,
   input  logic [NREQ*2*NBITS-1:0]        req_muestra,
   input  logic [NREQ*2*NBITScoeff-1:0]   req_coeff,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [2*NBITS_out-1:0]         out_result,
   output logic [$clog2(NREQ)-1:0]        out_id
);

   localparam int ID_W = $clog2(NREQ);
   localparam int MW   = 2 * NBITS;
   localparam int CW   = 2 * NBITScoeff;
   localparam int RW   = 2 * NBITS_out;

   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] win_idx;
   logic            win_found;
   rr_pick_t        pick;

   logic            s1_vld;
   logic [MW-1:0]   s1_m;
   logic [CW-1:0]   s1_c;
   logic [ID_W-1:0] s1_id;

   logic            adv2;
   logic            s1_load;
   logic            grant;
   logic [RW-1:0]   prod;

   // Pick this cycle's winner and decide whether the pipeline can take it.
   // Grant is also gated by rst_n so req_ready stays low for the whole reset window.
   always_comb begin
      pick      = rr_pick(NREQ_MAX'(req_valid), 3'(ptr), NREQ);
      win_idx   = ID_W'(pick.idx);
      win_found = pick.found;
      adv2      = !out_valid || out_ready;
      s1_load   = !s1_vld || adv2;
      grant     = win_found && s1_load && rst_n;
      req_ready = '0;
      if (grant) begin
         req_ready[win_idx] = 1'b1;
      end
   end

   // Round-robin pointer moves just past the lane that transferred; holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (grant) begin
         ptr <= win_idx + ID_W'(1);
      end
   end

   // Stage 1: capture granted operands and lane id; empties when stage 2 takes it and no new grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld <= 1'b0;
         s1_m   <= '0;
         s1_c   <= '0;
         s1_id  <= '0;
      end else if (s1_load) begin
         s1_vld <= grant;
         if (grant) begin
            s1_m  <= req_muestra[lane_lsb(int'(win_idx), NBITS) +: MW];
            s1_c  <= req_coeff[lane_lsb(int'(win_idx), NBITScoeff) +: CW];
            s1_id <= win_idx;
         end
      end
   end

   multip #(
      .NBITS      (NBITS),
      .NBITScoeff (NBITScoeff),
      .NBITS_out  (NBITS_out)
   ) u_multip (
      .muestra (s1_m),
      .coeff   (s1_c),
      .result  (prod)
   );

   // Stage 2: register the product; result and id hold while downstream stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_id     <= '0;
      end else if (adv2) begin
         out_valid <= s1_vld;
         if (s1_vld) begin
            out_result <= prod;
            out_id     <= s1_id;
         end
      end
   end

endmodule
